// File: rtl/conv3x3_mac_relu.sv
// conv3x3_mac_relu
// One output channel of a 3x3 convolution summed over all input channels.
// Weights and bias are loaded serially, then windows stream through a
// fixed 4-stage pipeline: multiply, per-channel sum, cross-channel sum plus
// bias, and ReLU/shift/saturate. A frame counter flags the last pixel.
module conv3x3_mac_relu #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int FILTER_SIZE  = 3,
  parameter int IMG_WIDTH    = 5,
  parameter int IMG_HEIGHT   = 5,
  parameter int ACC_WIDTH    = 32,
  parameter int SHIFT        = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_valid,
  input  logic [NUM_CHANNELS*9*DATA_WIDTH-1:0] i_windows_packed,
  input  logic                                i_wt_valid,
  input  logic [DATA_WIDTH-1:0]               i_wt_data,
  output logic                                o_wt_loaded,
  output logic                                o_valid,
  output logic [DATA_WIDTH-1:0]               o_data,
  output logic                                o_frame_done
);

  localparam int KN      = 9;                       // taps per channel
  localparam int NW      = NUM_CHANNELS * KN;       // weight slots
  localparam int PW      = 2 * DATA_WIDTH + 1;      // signed product width
  localparam int NPIX    = IMG_WIDTH * IMG_HEIGHT;
  localparam int WCW     = $clog2(NW + 1);          // counts 0..NW (NW = bias slot)
  localparam int PCW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int ACC_MIN = 2 * DATA_WIDTH + 1 + $clog2(NW);

  // Elaboration-time guards on the parameter set.
  generate
    if (FILTER_SIZE != 3) begin : g_bad_filter
      $error("conv3x3_mac_relu: FILTER_SIZE must be 3");
    end
    if (ACC_WIDTH < ACC_MIN) begin : g_bad_acc
      $error("conv3x3_mac_relu: ACC_WIDTH too narrow");
    end
  endgenerate

  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 r_state, w_state_next;
  logic [WCW-1:0]         r_wcnt, w_wcnt_next;
  logic                   w_wt_we, w_bias_we, w_accept;
  logic [WCW-1:0]         w_wt_addr;

  logic signed [DATA_WIDTH-1:0] r_wt [NW];
  logic signed [DATA_WIDTH-1:0] r_bias;

  logic signed [PW-1:0]         w_prod [NW];
  logic signed [PW-1:0]         r_prod [NW];
  logic                         r_v1, r_v2, r_v3;
  logic signed [DATA_WIDTH-1:0] r_bias1, r_bias2;

  logic signed [ACC_WIDTH-1:0]  w_chsum [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0]  r_chsum [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0]  w_total, r_acc;
  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic [DATA_WIDTH-1:0]        w_pix_out;

  logic                         r_valid, r_frame_done;
  logic [DATA_WIDTH-1:0]        r_data;
  logic [PCW-1:0]               r_pcnt;

  // State and load-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  // Next state, weight/bias write enables and window acceptance.
  // A load strobe in RUN restarts loading and wins over a same-cycle window.
  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    w_wt_we      = 1'b0;
    w_wt_addr    = r_wcnt;
    w_bias_we    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (i_wt_valid) begin
          if (r_wcnt == WCW'(NW)) begin
            w_bias_we    = 1'b1;
            w_wcnt_next  = '0;
            w_state_next = ST_RUN;
          end else begin
            w_wt_we     = 1'b1;
            w_wcnt_next = r_wcnt + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (i_wt_valid) begin
          w_wt_we      = 1'b1;
          w_wt_addr    = '0;
          w_wcnt_next  = WCW'(1);
          w_state_next = ST_LOAD;
        end else begin
          w_accept = i_valid;
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  // Weight and bias storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) r_wt[k] <= '0;
      r_bias <= '0;
    end else begin
      if (w_wt_we) r_wt[w_wt_addr] <= i_wt_data;
      if (w_bias_we) r_bias <= i_wt_data;
    end
  end

  // Per-tap product: unsigned pixel (zero-extended) times signed weight.
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_mul
      logic [PW-1:0] w_pix_ext, w_wt_ext;
      assign w_pix_ext  = {{(PW-DATA_WIDTH){1'b0}}, i_windows_packed[gi*DATA_WIDTH +: DATA_WIDTH]};
      assign w_wt_ext   = {{(PW-DATA_WIDTH){r_wt[gi][DATA_WIDTH-1]}}, r_wt[gi]};
      assign w_prod[gi] = $signed(w_pix_ext) * $signed(w_wt_ext);
    end
  endgenerate

  // Per-channel 9-tap sum of sign-extended products.
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chsum
      logic signed [ACC_WIDTH-1:0] w_acc;
      always_comb begin
        w_acc = '0;
        for (int k = 0; k < KN; k++) begin
          w_acc = w_acc + {{(ACC_WIDTH-PW){r_prod[gi*KN+k][PW-1]}}, r_prod[gi*KN+k]};
        end
      end
      assign w_chsum[gi] = w_acc;
    end
  endgenerate

  // Cross-channel sum plus bias carried alongside the window.
  always_comb begin
    w_total = {{(ACC_WIDTH-DATA_WIDTH){r_bias2[DATA_WIDTH-1]}}, r_bias2};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_total = w_total + r_chsum[c];
    end
  end

  // ReLU, arithmetic shift and saturation to an unsigned pixel.
  always_comb begin
    w_shifted = r_acc >>> SHIFT;
    if (r_acc[ACC_WIDTH-1]) begin
      w_pix_out = '0;
    end else if (|w_shifted[ACC_WIDTH-1:DATA_WIDTH]) begin
      w_pix_out = '1;
    end else begin
      w_pix_out = w_shifted[DATA_WIDTH-1:0];
    end
  end

  // Pipeline stages 1-3; bias travels with each window so a reload cannot
  // disturb results already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) r_prod[k] <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_chsum[c] <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_bias1 <= '0;
      r_bias2 <= '0;
      r_acc   <= '0;
    end else begin
      for (int k = 0; k < NW; k++) r_prod[k] <= w_prod[k];
      r_v1    <= w_accept;
      r_bias1 <= r_bias;
      for (int c = 0; c < NUM_CHANNELS; c++) r_chsum[c] <= w_chsum[c];
      r_v2    <= r_v1;
      r_bias2 <= r_bias1;
      r_acc   <= w_total;
      r_v3    <= r_v2;
    end
  end

  // Output stage and frame pixel counter; o_data holds between valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_pcnt       <= '0;
    end else begin
      r_valid      <= r_v3;
      r_frame_done <= 1'b0;
      if (r_v3) begin
        r_data <= w_pix_out;
        if (r_pcnt == PCW'(NPIX - 1)) begin
          r_frame_done <= 1'b1;
          r_pcnt       <= '0;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
        end
      end
    end
  end

  assign o_wt_loaded  = (r_state == ST_RUN);
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_frame_done = r_frame_done;

endmodule
